// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage occupancy tracking, hold/flush derivation and
// wrapping performance counters for the in-order core.
module pipe_ctrl #(
    parameter int NUM_STAGES = 8,
    parameter bit COLLAPSE   = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_log_fd,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [NUM_STAGES-1:0] i_stall_req,
    input  logic [NUM_STAGES-1:0] i_flush_req,
    output logic [NUM_STAGES-1:0] o_stall,
    output logic [NUM_STAGES-1:0] o_flush,
    output logic [NUM_STAGES-1:0] o_valid,
    output logic                  o_retire,
    output logic                  o_empty,
    input  logic                  i_cnt_clr,
    output logic [CNT_WIDTH-1:0]  o_cnt_cycle,
    output logic [CNT_WIDTH-1:0]  o_cnt_retire,
    output logic [CNT_WIDTH-1:0]  o_cnt_stall,
    output logic [CNT_WIDTH-1:0]  o_cnt_flush
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [NUM_STAGES-1:0] flush_q_req;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] hold;
    logic                  retire;
    logic [CNT_WIDTH-1:0]  cnt_cycle_q, cnt_cycle_d;
    logic [CNT_WIDTH-1:0]  cnt_retire_q, cnt_retire_d;
    logic [CNT_WIDTH-1:0]  cnt_stall_q, cnt_stall_d;
    logic [CNT_WIDTH-1:0]  cnt_flush_q, cnt_flush_d;
    logic                  unused_log;

    assign unused_log = ^i_log_fd;

    // Kill region and hold chain both resolve from the oldest stage downwards.
    always_comb begin
        flush_q_req = i_flush_req & v_q;
        kill        = '0;
        hold        = '0;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            kill[i] = kill[i+1] | flush_q_req[i+1];
        end
        if (COLLAPSE) begin
            hold[NUM_STAGES-1] = v_q[NUM_STAGES-1] & i_stall_req[NUM_STAGES-1];
            for (int i = NUM_STAGES - 2; i >= 0; i--) begin
                hold[i] = v_q[i] & (i_stall_req[i] | hold[i+1]);
            end
        end else begin
            hold[NUM_STAGES-1] = i_stall_req[NUM_STAGES-1];
            for (int i = NUM_STAGES - 2; i >= 0; i--) begin
                hold[i] = i_stall_req[i] | hold[i+1];
            end
        end
    end

    // A held stage keeps its occupancy, so a held bubble in legacy mode stays empty.
    always_comb begin
        v_d = '0;
        if (kill[0]) begin
            v_d[0] = 1'b0;
        end else if (hold[0]) begin
            v_d[0] = v_q[0];
        end else begin
            v_d[0] = i_in_valid;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (kill[i]) begin
                v_d[i] = 1'b0;
            end else if (hold[i]) begin
                v_d[i] = v_q[i];
            end else begin
                v_d[i] = v_q[i-1] & ~i_stall_req[i-1] & ~kill[i-1];
            end
        end
    end

    assign retire = v_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

    // Clear takes priority over every increment; all counters wrap naturally.
    always_comb begin
        cnt_cycle_d  = cnt_cycle_q + CNT_ONE;
        cnt_retire_d = retire ? cnt_retire_q + CNT_ONE : cnt_retire_q;
        cnt_stall_d  = (hold[0] & v_q[0]) ? cnt_stall_q + CNT_ONE : cnt_stall_q;
        cnt_flush_d  = (|flush_q_req) ? cnt_flush_q + CNT_ONE : cnt_flush_q;
        if (i_cnt_clr) begin
            cnt_cycle_d  = '0;
            cnt_retire_d = '0;
            cnt_stall_d  = '0;
            cnt_flush_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q          <= '0;
            cnt_cycle_q  <= '0;
            cnt_retire_q <= '0;
            cnt_stall_q  <= '0;
            cnt_flush_q  <= '0;
        end else begin
            v_q          <= v_d;
            cnt_cycle_q  <= cnt_cycle_d;
            cnt_retire_q <= cnt_retire_d;
            cnt_stall_q  <= cnt_stall_d;
            cnt_flush_q  <= cnt_flush_d;
        end
    end

    assign o_stall      = hold & ~kill;
    assign o_flush      = kill;
    assign o_valid      = v_q;
    assign o_in_ready   = ~hold[0] | kill[0];
    assign o_retire     = retire;
    assign o_empty      = ~|v_q;
    assign o_cnt_cycle  = cnt_cycle_q;
    assign o_cnt_retire = cnt_retire_q;
    assign o_cnt_stall  = cnt_stall_q;
    assign o_cnt_flush  = cnt_flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a legacy-mode and a
// 4-bit-counter instance sharing the same stimulus.
module tb_pipe_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_log_fd;
    logic        i_in_valid;
    logic [7:0]  i_stall_req;
    logic [7:0]  i_flush_req;
    logic        i_cnt_clr;

    logic        in_ready, retire, empty;
    logic [7:0]  stall, flush, valid;
    logic [31:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;

    logic        leg_in_ready, leg_retire, leg_empty;
    logic [7:0]  leg_stall, leg_flush, leg_valid;
    logic [31:0] leg_cnt_cycle, leg_cnt_retire, leg_cnt_stall, leg_cnt_flush;

    logic        w4_in_ready, w4_retire, w4_empty;
    logic [7:0]  w4_stall, w4_flush, w4_valid;
    logic [3:0]  w4_cnt_cycle, w4_cnt_retire, w4_cnt_stall, w4_cnt_flush;

    int tests_run;
    int tests_failed;

    pipe_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_log_fd(i_log_fd),
        .i_in_valid(i_in_valid), .o_in_ready(in_ready),
        .i_stall_req(i_stall_req), .i_flush_req(i_flush_req),
        .o_stall(stall), .o_flush(flush), .o_valid(valid),
        .o_retire(retire), .o_empty(empty), .i_cnt_clr(i_cnt_clr),
        .o_cnt_cycle(cnt_cycle), .o_cnt_retire(cnt_retire),
        .o_cnt_stall(cnt_stall), .o_cnt_flush(cnt_flush)
    );

    pipe_ctrl #(.NUM_STAGES(8), .COLLAPSE(1'b0), .CNT_WIDTH(32)) dut_leg (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_log_fd(i_log_fd),
        .i_in_valid(i_in_valid), .o_in_ready(leg_in_ready),
        .i_stall_req(i_stall_req), .i_flush_req(i_flush_req),
        .o_stall(leg_stall), .o_flush(leg_flush), .o_valid(leg_valid),
        .o_retire(leg_retire), .o_empty(leg_empty), .i_cnt_clr(i_cnt_clr),
        .o_cnt_cycle(leg_cnt_cycle), .o_cnt_retire(leg_cnt_retire),
        .o_cnt_stall(leg_cnt_stall), .o_cnt_flush(leg_cnt_flush)
    );

    pipe_ctrl #(.NUM_STAGES(8), .COLLAPSE(1'b1), .CNT_WIDTH(4)) dut_w4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_log_fd(i_log_fd),
        .i_in_valid(i_in_valid), .o_in_ready(w4_in_ready),
        .i_stall_req(i_stall_req), .i_flush_req(i_flush_req),
        .o_stall(w4_stall), .o_flush(w4_flush), .o_valid(w4_valid),
        .o_retire(w4_retire), .o_empty(w4_empty), .i_cnt_clr(i_cnt_clr),
        .o_cnt_cycle(w4_cnt_cycle), .o_cnt_retire(w4_cnt_retire),
        .o_cnt_stall(w4_cnt_stall), .o_cnt_flush(w4_cnt_flush)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Holds reset for two edges and releases it mid-cycle; next rising edge is edge 1.
    task automatic reset_dut();
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_stall_req = '0;
        i_flush_req = '0;
        i_cnt_clr   = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic fill_pipe();
        reset_dut();
        i_in_valid = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_flush_req = '0;
        i_cnt_clr   = 1'b0;
        i_stall_req = 8'h10;
        #3;
        tests_run++; if (valid !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_valid got %h want 00", valid); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
        tests_run++; if (retire !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_retire got %b want 0", retire); end
        tests_run++; if (flush !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_flush got %h want 00", flush); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (stall !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_stall got %h want 00", stall); end
        tests_run++; if (leg_stall !== 8'h1F) begin tests_failed++; $display("[TB] FAIL reset_leg_stall got %h want 1f", leg_stall); end
        tests_run++; if ({cnt_cycle, cnt_retire, cnt_stall, cnt_flush} !== 128'h0) begin
            tests_failed++; $display("[TB] FAIL reset_counters got %h %h %h %h want 0", cnt_cycle, cnt_retire, cnt_stall, cnt_flush);
        end
        reset_dut();
    endtask

    task automatic test_fill();
        logic [7:0] exp_v;
        reset_dut();
        i_in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = 8'((9'd1 << k) - 9'd1);
            tests_run++; if (valid !== exp_v) begin tests_failed++; $display("[TB] FAIL fill_valid_%0d got %h want %h", k, valid, exp_v); end
            tests_run++; if (retire !== (k == 8)) begin tests_failed++; $display("[TB] FAIL fill_retire_%0d got %b want %b", k, retire, (k == 8)); end
        end
        step();
        tests_run++; if (cnt_retire !== 32'd1) begin tests_failed++; $display("[TB] FAIL fill_cnt_retire got %0d want 1", cnt_retire); end
        tests_run++; if (cnt_cycle !== 32'd9) begin tests_failed++; $display("[TB] FAIL fill_cnt_cycle got %0d want 9", cnt_cycle); end
        tests_run++; if (valid !== 8'hFF) begin tests_failed++; $display("[TB] FAIL fill_steady got %h want ff", valid); end
    endtask

    task automatic test_bubble_collapse();
        logic [7:0] pattern;
        pattern = 8'b0000_0101;
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            i_in_valid = (k < 3) ? pattern[k] : 1'b0;
            step();
        end
        tests_run++; if (valid !== 8'b1010_0000) begin tests_failed++; $display("[TB] FAIL collapse_setup got %h want a0", valid); end
        i_stall_req = 8'h80;
        #1;
        tests_run++; if (stall !== 8'h80) begin tests_failed++; $display("[TB] FAIL collapse_stall got %h want 80", stall); end
        tests_run++; if (leg_stall !== 8'hFF) begin tests_failed++; $display("[TB] FAIL legacy_stall got %h want ff", leg_stall); end
        tests_run++; if (retire !== 1'b0) begin tests_failed++; $display("[TB] FAIL collapse_retire got %b want 0", retire); end
        step();
        tests_run++; if (valid !== 8'b1100_0000) begin tests_failed++; $display("[TB] FAIL collapse_move got %h want c0", valid); end
        tests_run++; if (cnt_stall !== 32'd0) begin tests_failed++; $display("[TB] FAIL collapse_cnt_stall got %0d want 0", cnt_stall); end
        i_stall_req = '0;
    endtask

    task automatic test_back_to_back();
        fill_pipe();
        i_stall_req = 8'h80;
        #1;
        tests_run++; if (stall !== 8'hFF) begin tests_failed++; $display("[TB] FAIL b2b_stall got %h want ff", stall); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_in_ready got %b want 0", in_ready); end
        step();
        tests_run++; if (cnt_stall !== 32'd1) begin tests_failed++; $display("[TB] FAIL b2b_cnt_stall got %0d want 1", cnt_stall); end
        tests_run++; if (cnt_retire !== 32'd0) begin tests_failed++; $display("[TB] FAIL b2b_cnt_retire0 got %0d want 0", cnt_retire); end
        i_stall_req = '0;
        repeat (3) step();
        tests_run++; if (cnt_retire !== 32'd3) begin tests_failed++; $display("[TB] FAIL b2b_cnt_retire got %0d want 3", cnt_retire); end
        tests_run++; if (valid !== 8'hFF) begin tests_failed++; $display("[TB] FAIL b2b_valid got %h want ff", valid); end
    endtask

    task automatic test_flush_over_stall();
        fill_pipe();
        i_flush_req = 8'h80;
        i_stall_req = 8'h08;
        #1;
        tests_run++; if (flush !== 8'h7F) begin tests_failed++; $display("[TB] FAIL fos_flush got %h want 7f", flush); end
        tests_run++; if (stall !== 8'h00) begin tests_failed++; $display("[TB] FAIL fos_stall got %h want 00", stall); end
        tests_run++; if (retire !== 1'b1) begin tests_failed++; $display("[TB] FAIL fos_retire got %b want 1", retire); end
        step();
        i_flush_req = '0;
        i_stall_req = '0;
        i_in_valid  = 1'b0;
        #1;
        tests_run++; if (valid !== 8'h00) begin tests_failed++; $display("[TB] FAIL fos_valid got %h want 00", valid); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL fos_empty got %b want 1", empty); end
        tests_run++; if (cnt_flush !== 32'd1) begin tests_failed++; $display("[TB] FAIL fos_cnt_flush got %0d want 1", cnt_flush); end
        tests_run++; if (cnt_retire !== 32'd1) begin tests_failed++; $display("[TB] FAIL fos_cnt_retire got %0d want 1", cnt_retire); end
    endtask

    task automatic test_nested_flush();
        fill_pipe();
        i_in_valid  = 1'b0;
        i_flush_req = 8'h48;
        #1;
        tests_run++; if (flush !== 8'h3F) begin tests_failed++; $display("[TB] FAIL nested_flush got %h want 3f", flush); end
        step();
        i_flush_req = '0;
        #1;
        tests_run++; if (valid !== 8'h80) begin tests_failed++; $display("[TB] FAIL nested_valid got %h want 80", valid); end
        tests_run++; if (cnt_flush !== 32'd1) begin tests_failed++; $display("[TB] FAIL nested_cnt_flush got %0d want 1", cnt_flush); end
        tests_run++; if (retire !== 1'b1) begin tests_failed++; $display("[TB] FAIL nested_retire got %b want 1", retire); end
    endtask

    task automatic test_invalid_flush();
        reset_dut();
        i_in_valid = 1'b1;
        repeat (2) step();
        i_in_valid  = 1'b0;
        i_flush_req = 8'h20;
        #1;
        tests_run++; if (valid !== 8'h03) begin tests_failed++; $display("[TB] FAIL inv_setup got %h want 03", valid); end
        tests_run++; if (flush !== 8'h00) begin tests_failed++; $display("[TB] FAIL inv_flush got %h want 00", flush); end
        step();
        i_flush_req = '0;
        tests_run++; if (cnt_flush !== 32'd0) begin tests_failed++; $display("[TB] FAIL inv_cnt_flush got %0d want 0", cnt_flush); end
        tests_run++; if (valid !== 8'h06) begin tests_failed++; $display("[TB] FAIL inv_valid got %h want 06", valid); end
    endtask

    task automatic test_counters();
        reset_dut();
        i_in_valid = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 23) begin
                tests_run++; if (w4_cnt_retire !== 4'd15) begin tests_failed++; $display("[TB] FAIL w4_retire_15 got %0d want 15", w4_cnt_retire); end
            end
        end
        tests_run++; if (w4_cnt_retire !== 4'd0) begin tests_failed++; $display("[TB] FAIL w4_retire_wrap got %0d want 0", w4_cnt_retire); end
        tests_run++; if (w4_cnt_cycle !== 4'd8) begin tests_failed++; $display("[TB] FAIL w4_cycle_wrap got %0d want 8", w4_cnt_cycle); end
        tests_run++; if (cnt_retire !== 32'd16) begin tests_failed++; $display("[TB] FAIL wide_retire got %0d want 16", cnt_retire); end
        i_cnt_clr = 1'b1;
        #1;
        tests_run++; if (w4_retire !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_in_retire got %b want 1", w4_retire); end
        step();
        i_cnt_clr = 1'b0;
        tests_run++; if ({w4_cnt_cycle, w4_cnt_retire, w4_cnt_stall, w4_cnt_flush} !== 16'h0) begin
            tests_failed++; $display("[TB] FAIL clr_w4 got %h %h %h %h want 0", w4_cnt_cycle, w4_cnt_retire, w4_cnt_stall, w4_cnt_flush);
        end
        tests_run++; if ({cnt_cycle, cnt_retire} !== 64'h0) begin tests_failed++; $display("[TB] FAIL clr_wide got %h %h want 0", cnt_cycle, cnt_retire); end
        step();
        tests_run++; if (cnt_cycle !== 32'd1) begin tests_failed++; $display("[TB] FAIL post_clr_cycle got %0d want 1", cnt_cycle); end
        tests_run++; if (cnt_retire !== 32'd1) begin tests_failed++; $display("[TB] FAIL post_clr_retire got %0d want 1", cnt_retire); end
        #2;
        i_rst_n = 1'b0;
        #1;
        tests_run++; if (valid !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_valid got %h want 00", valid); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_empty got %b want 1", empty); end
        tests_run++; if (cnt_cycle !== 32'd0) begin tests_failed++; $display("[TB] FAIL midreset_cycle got %0d want 0", cnt_cycle); end
        reset_dut();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_log_fd     = 32'd1;
        test_reset();
        test_fill();
        test_bubble_collapse();
        test_back_to_back();
        test_flush_over_stall();
        test_nested_flush();
        test_invalid_flush();
        test_counters();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
